minterm_sweeper: RTL and testbench

- Parametrised sequential successor to the fixed 3-input SoP evaluator.
- Latches an N-input boolean function given as a 2^N-bit minterm/maxterm mask, in SoP or PoS mode.
- Streams the complete truth table, one row per handshake, and reports how many rows evaluate to 1.
- Used as a self-checking truth-table source for the guide exercises and their benches.

---
 rtl/minterm_sweeper_pkg.sv | 13 +
 rtl/minterm_eval.sv | 17 +
 rtl/minterm_sweeper.sv | 117 +++++++++++
 tb/tb_minterm_sweeper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/minterm_sweeper_pkg.sv
// Shared encodings for the truth-table sweeper: FSM states and the SoP/PoS mode flag.
package minterm_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

endpackage

// File: rtl/minterm_eval.sv
// Combinational evaluation of one truth-table row from a minterm (SoP) or maxterm (PoS) mask.
module minterm_eval
  import minterm_sweeper_pkg::*;
#(
  parameter int N = 3,
  localparam int ROWS = 2**N
) (
  input  logic [ROWS-1:0] mask,
  input  logic [N-1:0]    idx,
  input  logic            mode,
  output logic            f
);

  // In PoS a set mask bit marks a maxterm, so the row evaluates to 0.
  assign f = (mode == MODE_POS) ? ~mask[idx] : mask[idx];

endmodule

// File: rtl/minterm_sweeper.sv
// Latches an N-input boolean function and streams its truth table row by row over a
// valid/ready handshake, counting the rows that evaluate to 1.
module minterm_sweeper
  import minterm_sweeper_pkg::*;
#(
  parameter int N = 3,
  localparam int ROWS = 2**N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ROWS-1:0] mask,
  input  logic            mode,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_idx,
  output logic            out_f,
  output logic            done,
  output logic [N:0]      count
);

  localparam logic [N-1:0] LAST_IDX = N'(ROWS - 1);

  state_t          state_q, state_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic            mode_q, mode_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            row_f;

  minterm_eval #(.N(N)) u_eval (
    .mask (mask_q),
    .idx  (idx_q),
    .mode (mode_q),
    .f    (row_f)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    count_d = count_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = mask;
          mode_d  = mode;
          idx_d   = '0;
          count_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (valid_q && out_ready) begin
          count_d = count_q + (N+1)'(row_f);
          // The last row ends the stream instead of wrapping the index.
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_f     = valid_q & row_f;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench for minterm_sweeper (N=3 and N=1) with a row scoreboard.
module tb_minterm_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mask = '0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, out_valid, out_f, done;
  logic [2:0] out_idx;
  logic [3:0] count;

  logic       start1 = 1'b0;
  logic [1:0] mask1 = '0;
  logic       mode1 = 1'b0;
  logic       ready1 = 1'b1;
  logic       busy1, valid1, f1, done1;
  logic [0:0] idx1;
  logic [1:0] count1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];

  minterm_sweeper #(.N(3)) dut (
    .clk(clk), .reset(reset), .start(start), .mask(mask), .mode(mode),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_f(out_f), .done(done), .count(count)
  );

  minterm_sweeper #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mask(mask1), .mode(mode1),
    .busy(busy1), .out_valid(valid1), .out_ready(ready1),
    .out_idx(idx1), .out_f(f1), .done(done1), .count(count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: SoP rows follow the mask bit, PoS rows are its complement.
  function automatic logic ref_f(input logic [7:0] m, input logic md, input int i);
    logic b;
    b = m[i];
    return md ? !b : b;
  endfunction

  // Scoreboard: a row is consumed whenever valid & ready is seen ahead of an edge.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset && out_valid && out_ready) begin
      chk("sb_has_row", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("row_idx", 32'(out_idx), 32'(e[3:1]));
        chk("row_f", 32'(out_f), 32'(e[0]));
        $display("row idx=%0d f=%0b count_before=%0d", out_idx, out_f, count);
      end
    end
    if (done) done_cnt++;
  end

  task automatic start_sweep(input logic [7:0] m, input logic md);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), ref_f(m, md, i)});
    @(posedge clk); #1;
    start = 1'b1; mask = m; mode = md; out_ready = 1'b1;
    @(posedge clk); #1;
    // Inputs move after the latch; the running sweep must ignore them.
    start = 1'b0; mask = ~m; mode = ~md;
  endtask

  task automatic run_sweep(input string tag, input logic [7:0] m, input logic md,
                           input int exp_cnt, input int exp_lat,
                           input int stall_idx, input int stall_len, input int inj_idx);
    int   stalled, cyc, d0;
    logic got_done;
    stalled = 0; cyc = 0; got_done = 1'b0; d0 = done_cnt;
    start_sweep(m, md);
    while (!got_done && cyc < 40) begin
      cyc++;
      if (out_valid && int'(out_idx) == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else out_ready = 1'b1;
      if (out_valid && int'(out_idx) == inj_idx) begin
        start = 1'b1; mask = ~m;
      end else start = 1'b0;
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_first_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_first_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_first_busy"}, 32'(busy), 32'd1);
        chk({tag, "_count_cleared"}, 32'(count), 32'd0);
      end
      if (!out_ready) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_idx"}, 32'(out_idx), 32'(stall_idx));
        chk({tag, "_stall_f"}, 32'(out_f), 32'(ref_f(m, md, stall_idx)));
      end
      if (done) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_done_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_dropped"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count_held"}, 32'(count), 32'(exp_cnt));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_one_done_pulse"}, 32'(done_cnt - d0), 32'd1);
    $display("sweep %s mask=%02h mode=%0b count=%0d cycles=%0d", tag, m, md, count, cyc);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_f", 32'(out_f), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_n1_valid", 32'(valid1), 32'd0);
    #10 reset = 1'b0;

    // N=1: rows 0,1 give f=0,1; done on the third cycle after start.
    @(posedge clk); #1;
    start1 = 1'b1; mask1 = 2'b10; mode1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0; mask1 = 2'b01;
    @(negedge clk);
    chk("n1_c1_valid", 32'(valid1), 32'd1);
    chk("n1_c1_idx", 32'(idx1), 32'd0);
    chk("n1_c1_f", 32'(f1), 32'd0);
    $display("n1 row idx=%0d f=%0b", idx1, f1);
    @(negedge clk);
    chk("n1_c2_idx", 32'(idx1), 32'd1);
    chk("n1_c2_f", 32'(f1), 32'd1);
    $display("n1 row idx=%0d f=%0b", idx1, f1);
    @(negedge clk);
    chk("n1_c3_done", 32'(done1), 32'd1);
    chk("n1_c3_valid", 32'(valid1), 32'd0);
    chk("n1_count", 32'(count1), 32'd1);
    $display("n1 sweep count=%0d", count1);

    run_sweep("sop_aa", 8'b10101010, 1'b0, 4, 9, -1, 0, -1);
    run_sweep("pos_01", 8'b00000001, 1'b1, 7, 9, -1, 0, -1);
    run_sweep("sop_ff", 8'hFF, 1'b0, 8, 9, -1, 0, -1);
    run_sweep("stall", 8'b10101010, 1'b0, 4, 12, 2, 3, -1);
    run_sweep("busy_start", 8'b00111100, 1'b0, 4, 9, -1, 0, 4);

    // Asynchronous reset between edges in the middle of a sweep.
    start_sweep(8'b10101010, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_idx == 3'd5) break;
    end
    chk("rst_mid_reached_idx5", 32'(out_idx), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_idx", 32'(out_idx), 32'd0);
    $display("async reset at idx 5: valid=%0b busy=%0b idx=%0d count=%0d", out_valid, busy, out_idx, count);
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    run_sweep("post_rst", 8'b01011010, 1'b1, 4, 9, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
